issue_ctrl: RTL and testbench

Issue controller placed between instruction decode and execute. It tracks pending register writebacks in a 32-entry scoreboard and stalls decode on RAW/WAW hazards. It also allows only one outstanding load/store, and counts stall cycles for performance monitoring. The decode-stage outputs (register indices, source types, wb, visit) drive it directly, and its issue/stall decision sequences the pipeline register between ID and EX.

---
 rtl/issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// Issue controller between decode and execute: a 32-entry writeback
// scoreboard for RAW/WAW hazards, a one-outstanding load/store gate, and a
// saturating stall-cycle counter for performance monitoring.
module issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  input  logic [4:0]  rs1_idx_i,
  input  logic [4:0]  rs2_idx_i,
  input  logic [4:0]  rd_idx_i,
  input  logic [1:0]  rs1_type_i,
  input  logic [1:0]  rs2_type_i,
  input  logic        wb_i,
  input  logic        visit_i,
  input  logic        ex_ready_i,
  input  logic        flush_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_idx_i,
  input  logic        mem_done_i,
  output logic        issue_o,
  output logic        stall_o,
  output logic [31:0] busy_o,
  output logic        mem_busy_o,
  output logic [31:0] stall_cnt_o
);

  // Register index width and the source-type code that reads the register
  // file (PC and immediate sources use other codes and never hazard).
  localparam int         REG_IDX = 5;
  localparam logic [1:0] RS_RAW  = 2'b00;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

  mem_state_t          mem_state;
  mem_state_t          mem_state_next;
  logic [31:0]         busy;
  logic [31:0]         busy_next;
  logic [31:0]         stall_cnt;
  logic                mem_busy;
  logic                hazard;
  logic                rs1_hazard;
  logic                rs2_hazard;
  logic                rd_hazard;
  logic                mem_hazard;
  logic                issue;
  logic                stall;
  logic [REG_IDX-1:0]  rd_idx;

  assign rd_idx = rd_idx_i;

  // Hazard detection looks only at registered state: a retiring writeback or
  // completing load/store releases its dependents one cycle later.
  always_comb begin
    rs1_hazard = (rs1_type_i == RS_RAW) && busy[rs1_idx_i];
    rs2_hazard = (rs2_type_i == RS_RAW) && busy[rs2_idx_i];
    rd_hazard  = wb_i && (rd_idx != '0) && busy[rd_idx];
    mem_hazard = visit_i && mem_busy;
    hazard     = rs1_hazard || rs2_hazard || rd_hazard || mem_hazard;
  end

  // Issue/stall decision for the current decode slot; a flush squashes the
  // slot so it neither issues nor counts as a stall.
  always_comb begin
    issue = rst_n && id_valid_i && !flush_i && !hazard && ex_ready_i;
    stall = rst_n && id_valid_i && !flush_i && (hazard || !ex_ready_i);
  end

  // Next scoreboard: clear the retiring register, then set the issuing
  // destination so a same-index set overrides the clear. x0 never tracks.
  always_comb begin
    busy_next = busy;
    if (wb_valid_i && (wb_idx_i != '0)) begin
      busy_next[wb_idx_i] = 1'b0;
    end
    if (issue && wb_i && (rd_idx != '0)) begin
      busy_next[rd_idx] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Memory FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_state <= MEM_IDLE;
    end else begin
      mem_state <= mem_state_next;
    end
  end

  // Memory FSM next state: a load/store issuing claims the port until its
  // completion; completions seen while idle are stale and ignored.
  always_comb begin
    mem_state_next = mem_state;
    case (mem_state)
      MEM_IDLE: begin
        if (issue && visit_i) begin
          mem_state_next = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        if (mem_done_i) begin
          mem_state_next = MEM_IDLE;
        end
      end
      default: mem_state_next = MEM_IDLE;
    endcase
  end

  // Memory FSM outputs.
  always_comb begin
    mem_busy = (mem_state == MEM_BUSY);
  end

  // Stall-cycle counter, saturating at all ones so it never wraps to a
  // misleadingly small value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign issue_o     = issue;
  assign stall_o     = stall;
  assign busy_o      = busy;
  assign mem_busy_o  = mem_busy;
  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard-style bench for issue_ctrl: each cycle's stimulus pushes the
// expected outputs from a behavioural model; a monitor pops and compares.
module tb_issue_ctrl;

  localparam logic [1:0] RS_RAW = 2'b00;
  localparam logic [1:0] RS_PC  = 2'b01;
  localparam logic [1:0] RS_IMM = 2'b10;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [1:0]  rs1_type;
  logic [1:0]  rs2_type;
  logic        wb;
  logic        visit;
  logic        ex_ready;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic        mem_done;
  logic        issue;
  logic        stall;
  logic [31:0] busy;
  logic        mem_busy;
  logic [31:0] stall_cnt;

  typedef struct {
    logic        issue;
    logic        stall;
    logic [31:0] busy;
    logic        mem_busy;
    logic [31:0] stall_cnt;
  } exp_t;

  exp_t exp_q[$];

  int checks;
  int errors;

  // Behavioural model: which registers have a write in flight, whether a
  // memory access is outstanding, and how many stall cycles were seen.
  bit      pending[32];
  bit      mem_outstanding;
  longint  stall_total;

  issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid_i  (id_valid),
    .rs1_idx_i   (rs1_idx),
    .rs2_idx_i   (rs2_idx),
    .rd_idx_i    (rd_idx),
    .rs1_type_i  (rs1_type),
    .rs2_type_i  (rs2_type),
    .wb_i        (wb),
    .visit_i     (visit),
    .ex_ready_i  (ex_ready),
    .flush_i     (flush),
    .wb_valid_i  (wb_valid),
    .wb_idx_i    (wb_idx),
    .mem_done_i  (mem_done),
    .issue_o     (issue),
    .stall_o     (stall),
    .busy_o      (busy),
    .mem_busy_o  (mem_busy),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic setIdle();
    rst_n    = 1'b1;
    id_valid = 1'b0;
    rs1_idx  = 5'd0;
    rs2_idx  = 5'd0;
    rd_idx   = 5'd0;
    rs1_type = RS_IMM;
    rs2_type = RS_IMM;
    wb       = 1'b0;
    visit    = 1'b0;
    ex_ready = 1'b1;
    flush    = 1'b0;
    wb_valid = 1'b0;
    wb_idx   = 5'd0;
    mem_done = 1'b0;
  endtask

  // Called just after a rising edge with the inputs already driven: predicts
  // this cycle's outputs, queues them, advances the model across the next
  // edge and waits for it.
  task automatic applyStimulus();
    exp_t e;
    bit   blocked;
    logic [31:0] busy_vec;
    busy_vec = '0;
    for (int i = 1; i < 32; i++) busy_vec[i] = pending[i];
    blocked = (rs1_type == RS_RAW && pending[rs1_idx]) ||
              (rs2_type == RS_RAW && pending[rs2_idx]) ||
              (wb && rd_idx != 0 && pending[rd_idx]) ||
              (visit && mem_outstanding);
    e.issue     = rst_n && id_valid && !flush && !blocked && ex_ready;
    e.stall     = rst_n && id_valid && !flush && (blocked || !ex_ready);
    e.busy      = busy_vec;
    e.mem_busy  = mem_outstanding;
    e.stall_cnt = stall_total[31:0];
    exp_q.push_back(e);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) pending[i] = 1'b0;
      mem_outstanding = 1'b0;
      stall_total = 0;
    end else begin
      if (wb_valid && wb_idx != 0) pending[wb_idx] = 1'b0;
      if (e.issue && wb && rd_idx != 0) pending[rd_idx] = 1'b1;
      if (mem_outstanding) begin
        if (mem_done) mem_outstanding = 1'b0;
      end else if (e.issue && visit) begin
        mem_outstanding = 1'b1;
      end
      if (e.stall && stall_total < 64'hFFFF_FFFF) stall_total++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the queued prediction against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("issue", {31'd0, issue}, {31'd0, e.issue});
        checkOutput("stall", {31'd0, stall}, {31'd0, e.stall});
        checkOutput("busy", busy, e.busy);
        checkOutput("mem_busy", {31'd0, mem_busy}, {31'd0, e.mem_busy});
        checkOutput("stall_cnt", stall_cnt, e.stall_cnt);
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) pending[i] = 1'b0;
    mem_outstanding = 1'b0;
    stall_total = 0;
    setIdle();
    rst_n = 1'b0;
    id_valid = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with a valid decode slot.
    applyStimulus();
    applyStimulus();
    setIdle();
    applyStimulus();

    // RAW on x5, released the cycle after writeback.
    id_valid = 1'b1; rd_idx = 5'd5; wb = 1'b1;
    applyStimulus();
    rs1_idx = 5'd5; rs1_type = RS_RAW; rd_idx = 5'd6;
    applyStimulus();
    wb_valid = 1'b1; wb_idx = 5'd5;
    applyStimulus();
    wb_valid = 1'b0;
    applyStimulus();

    // x0 destination and a PC-type source on a busy register.
    setIdle();
    id_valid = 1'b1; rd_idx = 5'd0; wb = 1'b1;
    applyStimulus();
    wb = 1'b0; rs1_idx = 5'd6; rs1_type = RS_PC;
    applyStimulus();
    setIdle();
    wb_valid = 1'b1; wb_idx = 5'd6;
    applyStimulus();

    // Load then store: store waits until after mem_done; stale done ignored.
    setIdle();
    id_valid = 1'b1; visit = 1'b1; wb = 1'b1; rd_idx = 5'd9;
    applyStimulus();
    wb = 1'b0; rd_idx = 5'd0;
    applyStimulus();
    applyStimulus();
    mem_done = 1'b1;
    applyStimulus();
    mem_done = 1'b0;
    applyStimulus();
    setIdle();
    mem_done = 1'b1;
    applyStimulus();
    applyStimulus();
    mem_done = 1'b0;
    wb_valid = 1'b1; wb_idx = 5'd9;
    applyStimulus();

    // Clear of x3 alongside a set of x7, then a flushed hazard.
    setIdle();
    id_valid = 1'b1; wb = 1'b1; rd_idx = 5'd3;
    applyStimulus();
    rd_idx = 5'd7; wb_valid = 1'b1; wb_idx = 5'd3;
    applyStimulus();
    setIdle();
    id_valid = 1'b1; rs1_idx = 5'd7; rs1_type = RS_RAW; flush = 1'b1;
    applyStimulus();
    applyStimulus();

    // Same-index set and clear: set wins.
    setIdle();
    wb_valid = 1'b1; wb_idx = 5'd7;
    applyStimulus();
    setIdle();
    id_valid = 1'b1; wb = 1'b1; rd_idx = 5'd4; wb_valid = 1'b1; wb_idx = 5'd4;
    applyStimulus();
    setIdle();
    applyStimulus();

    // Counter: fresh reset, then ten back-pressured cycles.
    rst_n = 1'b0;
    applyStimulus();
    setIdle();
    id_valid = 1'b1; ex_ready = 1'b0;
    repeat (10) applyStimulus();
    setIdle();
    applyStimulus();
    checkOutput("stall_cnt_ten", stall_cnt, 32'd10);

    // Saturation: preload the counter close to the top.
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    stall_total = 64'h0000_0000_FFFF_FFFD;
    id_valid = 1'b1; ex_ready = 1'b0;
    repeat (5) applyStimulus();
    setIdle();
    applyStimulus();
    checkOutput("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      id_valid = ($urandom_range(0, 9) < 8);
      rs1_idx  = 5'($urandom_range(0, 7));
      rs2_idx  = 5'($urandom_range(0, 7));
      rd_idx   = 5'($urandom_range(0, 7));
      rs1_type = 2'($urandom_range(0, 3));
      rs2_type = 2'($urandom_range(0, 3));
      wb       = ($urandom_range(0, 1) == 1);
      visit    = ($urandom_range(0, 9) < 3);
      ex_ready = ($urandom_range(0, 9) < 8);
      flush    = ($urandom_range(0, 9) == 0);
      wb_valid = ($urandom_range(0, 9) < 4);
      wb_idx   = 5'($urandom_range(0, 7));
      mem_done = ($urandom_range(0, 9) < 3);
      applyStimulus();
    end
    setIdle();

    // Drain the scoreboard with a bounded wait.
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
